msrv32_wb_sched_unit: RTL and testbench

Writeback scheduler for the msrv32 core. It sits between the register stage and `msrv32_wb_mux_sel_unit`. It registers the writeback select and destination, and generates the integer register-file write enable. It stalls the front end while a load (LU) or CSR result is outstanding, and aborts loads that never complete.

---
 rtl/msrv32_wb_sched_if.sv | 29 ++
 rtl/msrv32_wb_sched_unit.sv | 99 +++++++++
 tb/tb_msrv32_wb_sched_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_wb_sched_if.sv
// Writeback scheduler bus: register-stage request, memory/CSR handshakes and WB-mux facing outputs.
interface msrv32_wb_sched_if;
    logic       instr_valid_in;
    logic [2:0] wb_mux_sel_in;
    logic [4:0] rd_addr_in;
    logic       rf_wr_en_in;
    logic       load_data_valid_in;
    logic       csr_ready_in;
    logic       flush_in;
    logic [2:0] wb_mux_sel_reg_out;
    logic [4:0] rd_addr_reg_out;
    logic       wr_en_int_out;
    logic       stall_out;
    logic       load_fault_out;

    modport master (
        output instr_valid_in, wb_mux_sel_in, rd_addr_in, rf_wr_en_in,
               load_data_valid_in, csr_ready_in, flush_in,
        input  wb_mux_sel_reg_out, rd_addr_reg_out, wr_en_int_out,
               stall_out, load_fault_out
    );

    modport slave (
        input  instr_valid_in, wb_mux_sel_in, rd_addr_in, rf_wr_en_in,
               load_data_valid_in, csr_ready_in, flush_in,
        output wb_mux_sel_reg_out, rd_addr_reg_out, wr_en_int_out,
               stall_out, load_fault_out
    );
endinterface

// File: rtl/msrv32_wb_sched_unit.sv
// Writeback scheduler: registers WB select/rd, gates the RF write and stalls on outstanding LU/CSR.
// Optional load/CSR timeout enabled by `define MSRV32_WB_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | nothing outstanding
//   WAIT_LU  | waiting on load data
//   WAIT_CSR | waiting on CSR read data
module msrv32_wb_sched_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    msrv32_wb_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_LU, WAIT_CSR} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 31 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
        $error("msrv32_wb_sched_unit: illegal TIMEOUT_CYCLES/CNT_W");
    end

    state_t     state, state_nxt;
    logic [2:0] sel_q;
    logic [4:0] rd_q;
    logic       we_q;
    logic       single_wr_q;
    logic       waiting, completion, timeout, stall, accept;
    logic       sel_lu, sel_csr, sel_single, we_in;

    assign sel_lu     = (bus.wb_mux_sel_in == 3'b001);
    assign sel_csr    = (bus.wb_mux_sel_in == 3'b100);
    assign sel_single = (bus.wb_mux_sel_in == 3'b000) || (bus.wb_mux_sel_in == 3'b010) ||
                        (bus.wb_mux_sel_in == 3'b011) || (bus.wb_mux_sel_in == 3'b101);
    // Reserved selects are accepted but can never write.
    assign we_in      = bus.rf_wr_en_in & (bus.rd_addr_in != 5'd0) & (sel_single | sel_lu | sel_csr);

    assign waiting    = (state != IDLE);
    assign completion = ((state == WAIT_LU)  & bus.load_data_valid_in) |
                        ((state == WAIT_CSR) & bus.csr_ready_in);
    assign stall      = waiting & ~completion & ~timeout & ~bus.flush_in;
    assign accept     = bus.instr_valid_in & ~stall & ~bus.flush_in;

`ifdef MSRV32_WB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (waiting & ~completion & ~bus.flush_in) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = waiting & ~completion & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state       <= IDLE;
            sel_q       <= 3'b000;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            single_wr_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            single_wr_q <= accept & sel_single & we_in;
            if (accept) begin
                sel_q <= bus.wb_mux_sel_in;
                rd_q  <= bus.rd_addr_in;
                we_q  <= we_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (sel_lu) begin
                state_nxt = WAIT_LU;
            end else if (sel_csr) begin
                state_nxt = WAIT_CSR;
            end else begin
                state_nxt = IDLE;
            end
        end else if (waiting & (completion | timeout | bus.flush_in)) begin
            state_nxt = IDLE;
        end
    end

    // Flush outranks completion and timeout: it drops both the write and the fault.
    assign bus.wr_en_int_out      = (single_wr_q | (completion & we_q)) & ~bus.flush_in;
    assign bus.load_fault_out     = timeout & ~bus.flush_in;
    assign bus.stall_out          = stall;
    assign bus.wb_mux_sel_reg_out = sel_q;
    assign bus.rd_addr_reg_out    = rd_q;
endmodule

// File: tb/tb_msrv32_wb_sched_unit.sv
// Scoreboard bench for msrv32_wb_sched_unit; expected writes queued at issue, popped on wr_en_int_out.
`timescale 1ns/1ps
module tb_msrv32_wb_sched_unit;
    localparam int TO = 16;

    typedef struct packed {
        logic [2:0] sel;
        logic [4:0] rd;
    } wr_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    wr_t  exp_q[$];
    logic prev_fault;

    msrv32_wb_sched_if bus();

    msrv32_wb_sched_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.wr_en_int_out === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: got rd=%0d sel=%0d, required no write", bus.rd_addr_reg_out, bus.wb_mux_sel_reg_out);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.rd_addr_reg_out !== e.rd || bus.wb_mux_sel_reg_out !== e.sel) begin
                    miscompares++;
                    $display("FAIL sb_write: got rd=%0d sel=%0d, required rd=%0d sel=%0d", bus.rd_addr_reg_out, bus.wb_mux_sel_reg_out, e.rd, e.sel);
                end
            end
        end
        if (!rst && bus.load_fault_out === 1'b1) begin
            vectors++;
            if (prev_fault) begin
                miscompares++;
                $display("FAIL fault_pulse_width: got two consecutive fault cycles, required one");
            end
        end
        prev_fault = (bus.load_fault_out === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.instr_valid_in     = 1'b0;
        bus.wb_mux_sel_in      = 3'b000;
        bus.rd_addr_in         = 5'd0;
        bus.rf_wr_en_in        = 1'b0;
        bus.load_data_valid_in = 1'b0;
        bus.csr_ready_in       = 1'b0;
        bus.flush_in           = 1'b0;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic we);
        bus.instr_valid_in = 1'b1;
        bus.wb_mux_sel_in  = sel;
        bus.rd_addr_in     = rd;
        bus.rf_wr_en_in    = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) step();
        @(negedge clk);
        vectors++; if (bus.wb_mux_sel_reg_out !== 3'b000) begin miscompares++; $display("FAIL reset_sel: got %0d, required 0", bus.wb_mux_sel_reg_out); end
        vectors++; if (bus.rd_addr_reg_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd: got %0d, required 0", bus.rd_addr_reg_out); end
        vectors++; if (bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b, required 0", bus.wr_en_int_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b, required 0", bus.stall_out); end
        vectors++; if (bus.load_fault_out !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b, required 0", bus.load_fault_out); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        step(); clear_inputs(); issue(3'b000, 5'd5, 1'b1); exp_q.push_back('{3'b000, 5'd5});
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_t0: got %b, required 0", bus.stall_out); end
        step(); clear_inputs(); issue(3'b101, 5'd6, 1'b1); exp_q.push_back('{3'b101, 5'd6});
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_t1: got %b, required 1", bus.wr_en_int_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_t1: got %b, required 0", bus.stall_out); end
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_t2: got %b, required 1", bus.wr_en_int_out); end
        vectors++; if (bus.rd_addr_reg_out !== 5'd6) begin miscompares++; $display("FAIL b2b_rd_t2: got %0d, required 6", bus.rd_addr_reg_out); end
        step();
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_t3: got %b, required 0", bus.wr_en_int_out); end
    endtask

    task automatic test_load_wait();
        step(); clear_inputs(); issue(3'b001, 5'd7, 1'b1); exp_q.push_back('{3'b001, 5'd7});
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b1) begin miscompares++; $display("FAIL lu_stall_t1: got %b, required 1", bus.stall_out); end
        vectors++; if (bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL lu_wr_t1: got %b, required 0", bus.wr_en_int_out); end
        step();
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b1) begin miscompares++; $display("FAIL lu_stall_t2: got %b, required 1", bus.stall_out); end
        step(); bus.load_data_valid_in = 1'b1; issue(3'b000, 5'd9, 1'b1); exp_q.push_back('{3'b000, 5'd9});
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL lu_stall_t3: got %b, required 0", bus.stall_out); end
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL lu_wr_t3: got %b, required 1", bus.wr_en_int_out); end
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL lu_next_wr_t4: got %b, required 1", bus.wr_en_int_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL lu_stall_t4: got %b, required 0", bus.stall_out); end
    endtask

    task automatic test_timeout();
        step(); clear_inputs(); issue(3'b001, 5'd8, 1'b1);
`ifdef MSRV32_WB_TIMEOUT_EN
        step(); clear_inputs();
        for (int k = 1; k < TO; k++) begin
            if (k > 1) step();
            @(negedge clk);
            vectors++; if (bus.stall_out !== 1'b1 || bus.load_fault_out !== 1'b0) begin miscompares++; $display("FAIL to_wait_t%0d: got stall=%b fault=%b, required stall=1 fault=0", k, bus.stall_out, bus.load_fault_out); end
        end
        step();
        @(negedge clk);
        vectors++; if (bus.load_fault_out !== 1'b1) begin miscompares++; $display("FAIL to_fault: got %b, required 1", bus.load_fault_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL to_stall: got %b, required 0", bus.stall_out); end
        vectors++; if (bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL to_wr: got %b, required 0", bus.wr_en_int_out); end
        step();
        @(negedge clk);
        vectors++; if (bus.load_fault_out !== 1'b0 || bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL to_after: got fault=%b stall=%b, required 0 0", bus.load_fault_out, bus.stall_out); end
`else
        exp_q.push_back('{3'b001, 5'd8});
        step(); clear_inputs();
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) step();
            @(negedge clk);
            vectors++; if (bus.stall_out !== 1'b1 || bus.load_fault_out !== 1'b0) begin miscompares++; $display("FAIL nto_wait_t%0d: got stall=%b fault=%b, required stall=1 fault=0", k, bus.stall_out, bus.load_fault_out); end
        end
        step(); bus.load_data_valid_in = 1'b1;
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL nto_wr: got %b, required 1", bus.wr_en_int_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL nto_stall: got %b, required 0", bus.stall_out); end
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL nto_idle: got %b, required 0", bus.stall_out); end
`endif
    endtask

    task automatic test_flush_csr();
        step(); clear_inputs(); issue(3'b100, 5'd10, 1'b1);
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b1) begin miscompares++; $display("FAIL fl_stall_t1: got %b, required 1", bus.stall_out); end
        step(); bus.flush_in = 1'b1; bus.csr_ready_in = 1'b1;
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL fl_wr_t2: got %b, required 0", bus.wr_en_int_out); end
        vectors++; if (bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL fl_stall_t2: got %b, required 0", bus.stall_out); end
        step(); clear_inputs(); issue(3'b000, 5'd11, 1'b1); exp_q.push_back('{3'b000, 5'd11});
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b0 || bus.wr_en_int_out !== 1'b0) begin miscompares++; $display("FAIL fl_idle_t3: got stall=%b wr=%b, required 0 0", bus.stall_out, bus.wr_en_int_out); end
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b1) begin miscompares++; $display("FAIL fl_next_wr_t4: got %b, required 1", bus.wr_en_int_out); end
    endtask

    task automatic test_edge_cases();
        step(); clear_inputs(); issue(3'b001, 5'd0, 1'b1);
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.stall_out !== 1'b1) begin miscompares++; $display("FAIL x0_stall: got %b, required 1", bus.stall_out); end
        step(); bus.load_data_valid_in = 1'b1;
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b0 || bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL x0_done: got wr=%b stall=%b, required 0 0", bus.wr_en_int_out, bus.stall_out); end
        step(); clear_inputs(); issue(3'b110, 5'd12, 1'b1);
        step(); clear_inputs();
        @(negedge clk);
        vectors++; if (bus.wr_en_int_out !== 1'b0 || bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL rsv_out: got wr=%b stall=%b, required 0 0", bus.wr_en_int_out, bus.stall_out); end
        vectors++; if (bus.wb_mux_sel_reg_out !== 3'b110 || bus.rd_addr_reg_out !== 5'd12) begin miscompares++; $display("FAIL rsv_regs: got sel=%0d rd=%0d, required 6 12", bus.wb_mux_sel_reg_out, bus.rd_addr_reg_out); end
    endtask

    task automatic test_reset_mid_wait();
        step(); clear_inputs(); issue(3'b001, 5'd13, 1'b1);
        step(); clear_inputs();
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus.wb_mux_sel_reg_out !== 3'b000 || bus.rd_addr_reg_out !== 5'd0) begin miscompares++; $display("FAIL rmw_regs: got sel=%0d rd=%0d, required 0 0", bus.wb_mux_sel_reg_out, bus.rd_addr_reg_out); end
        vectors++; if (bus.stall_out !== 1'b0 || bus.wr_en_int_out !== 1'b0 || bus.load_fault_out !== 1'b0) begin miscompares++; $display("FAIL rmw_outs: got stall=%b wr=%b fault=%b, required 0 0 0", bus.stall_out, bus.wr_en_int_out, bus.load_fault_out); end
        for (int k = 0; k < TO + 4; k++) begin
            step();
            @(negedge clk);
            vectors++; if (bus.load_fault_out !== 1'b0 || bus.stall_out !== 1'b0) begin miscompares++; $display("FAIL rmw_quiet_%0d: got fault=%b stall=%b, required 0 0", k, bus.load_fault_out, bus.stall_out); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_fault  = 1'b0;
        rst         = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_timeout();
        test_flush_csr();
        test_edge_cases();
        test_reset_mid_wait();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
